// File: rtl/shift_reg_sipo_rx_if.sv
// Serial-in receive bus: strobe/direction/data/clear from the line side, word + handshake to the consumer.
interface shift_reg_sipo_rx_if #(
    parameter int N = 8
);
    logic         en;
    logic         right;
    logic         serial_i;
    logic         clear;
    logic         ready_i;
    logic [N-1:0] data_o;
    logic         valid_o;
    logic         overrun_o;
    logic         parity_err_o;

    modport master (
        output en, right, serial_i, clear, ready_i,
        input  data_o, valid_o, overrun_o, parity_err_o
    );

    modport slave (
        input  en, right, serial_i, clear, ready_i,
        output data_o, valid_o, overrun_o, parity_err_o
    );
endinterface

// File: rtl/shift_reg_sipo_rx.sv
// Serial-to-parallel receiver: word valid on the edge of its last bit (0 extra latency); a word that completes
// while the previous one is still unconsumed is dropped and flagged sticky overrun. SIPO_PARITY_EN adds an even-parity bit.
module shift_reg_sipo_rx #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_reg_sipo_rx_if.slave   bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

`ifdef SIPO_PARITY_EN
    typedef enum logic {COLLECT = 1'b0, PARITY = 1'b1} state_t;
`else
    typedef enum logic {COLLECT = 1'b0} state_t;
`endif

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_shreg, w_shreg_nxt, w_shifted, w_word;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_dir, w_dir_nxt, w_dir_cur;
    logic [N-1:0]   r_data, w_data_nxt;
    logic           r_valid, w_valid_nxt;
    logic           r_overrun, w_overrun_nxt;
    logic           w_complete;
`ifdef SIPO_PARITY_EN
    logic           r_perr, w_perr_nxt, w_perr_new;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= COLLECT;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_dir     <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
`ifdef SIPO_PARITY_EN
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dir     <= w_dir_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_overrun <= w_overrun_nxt;
`ifdef SIPO_PARITY_EN
            r_perr    <= w_perr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_cnt_nxt     = r_cnt;
        w_dir_nxt     = r_dir;
        w_complete    = 1'b0;
        w_word        = r_shreg;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = r_overrun;
`ifdef SIPO_PARITY_EN
        w_perr_new    = 1'b0;
        w_perr_nxt    = r_perr;
`endif
        // Direction is sampled only on the first bit of a word; mid-word changes are ignored.
        w_dir_cur = (r_cnt == '0) ? bus.right : r_dir;
        w_shifted = w_dir_cur ? {bus.serial_i, r_shreg[N-1:1]} : {r_shreg[N-2:0], bus.serial_i};

        if (bus.clear) begin
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = COLLECT;
        end else if (bus.en) begin
            case (r_state)
                COLLECT: begin
                    w_shreg_nxt = w_shifted;
                    w_dir_nxt   = w_dir_cur;
                    if (r_cnt == CW'(N - 1)) begin
                        w_cnt_nxt = '0;
`ifdef SIPO_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_complete  = 1'b1;
                        w_word      = w_shifted;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    w_complete  = 1'b1;
                    w_word      = r_shreg;
                    w_perr_new  = (^r_shreg) ^ bus.serial_i;
                    w_state_nxt = COLLECT;
                end
`endif
                default: w_state_nxt = COLLECT;
            endcase
        end

        // Consumer side: a completing word replaces data only if the slot is free or being drained now.
        if (w_complete) begin
            if (!r_valid || bus.ready_i) begin
                w_data_nxt  = w_word;
                w_valid_nxt = 1'b1;
`ifdef SIPO_PARITY_EN
                w_perr_nxt  = w_perr_new;
`endif
            end else begin
                w_overrun_nxt = 1'b1;
            end
        end else if (r_valid && bus.ready_i) begin
            w_valid_nxt = 1'b0;
        end

        if (bus.clear) begin
            w_overrun_nxt = 1'b0;
        end
    end

    assign bus.data_o    = r_data;
    assign bus.valid_o   = r_valid;
    assign bus.overrun_o = r_overrun;
`ifdef SIPO_PARITY_EN
    assign bus.parity_err_o = r_perr;
`else
    assign bus.parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// Directed bench for shift_reg_sipo_rx (N=8); works with or without SIPO_PARITY_EN.
module tb_shift_reg_sipo_rx;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    shift_reg_sipo_rx_if #(.N(8)) bus ();

    shift_reg_sipo_rx #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.en       = 1'b1;
        bus.serial_i = b;
        tick();
        bus.en       = 1'b0;
        bus.serial_i = 1'($urandom);
    endtask

    // Transmission order: v[7] first, v[0] last. With parity enabled a correct even-parity bit follows.
    task automatic send_seq(input logic [7:0] v, input logic r);
        bus.right = r;
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
`ifdef SIPO_PARITY_EN
        send_bit(^v);
`endif
    endtask

    task automatic consume();
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (bus.data_o !== 8'h00) begin bad++; $display("FAIL reset_data got %h want 00", bus.data_o); end
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.valid_o); end
        total++; if (bus.overrun_o !== 1'b0) begin bad++; $display("FAIL reset_overrun got %b want 0", bus.overrun_o); end
        total++; if (bus.parity_err_o !== 1'b0) begin bad++; $display("FAIL reset_perr got %b want 0", bus.parity_err_o); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_msb_first();
        logic [7:0] seq;
        seq = 8'b10101100;
        bus.right = 1'b0;
        for (int i = 7; i >= 1; i--) send_bit(seq[i]);
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL msb_early_valid got %b want 0", bus.valid_o); end
        send_bit(seq[0]);
`ifdef SIPO_PARITY_EN
        send_bit(1'b0);
`endif
        total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL msb_valid got %b want 1", bus.valid_o); end
        total++; if (bus.data_o !== 8'hAC) begin bad++; $display("FAIL msb_data got %h want ac", bus.data_o); end
        total++; if (bus.parity_err_o !== 1'b0) begin bad++; $display("FAIL msb_perr got %b want 0", bus.parity_err_o); end
        consume();
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL consume_valid got %b want 0", bus.valid_o); end
        // Same word with idle gaps and garbage on serial_i while en=0.
        for (int i = 7; i >= 0; i--) begin
            send_bit(seq[i]);
            bus.serial_i = ~seq[i];
            repeat (i % 3) tick();
        end
`ifdef SIPO_PARITY_EN
        send_bit(1'b0);
`endif
        total++; if (bus.data_o !== 8'hAC || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL gap_word got %h/%b want ac/1", bus.data_o, bus.valid_o); end
        repeat (3) tick();
        total++; if (bus.data_o !== 8'hAC || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL idle_hold got %h/%b want ac/1", bus.data_o, bus.valid_o); end
        consume();
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq;
        seq = 8'b10000110;
        send_seq(seq, 1'b1);
        total++; if (bus.data_o !== 8'h61) begin bad++; $display("FAIL lsb_data got %h want 61", bus.data_o); end
        consume();
        bus.right = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i == 4) bus.right = 1'b0;
            send_bit(seq[i]);
        end
`ifdef SIPO_PARITY_EN
        send_bit(^seq);
`endif
        total++; if (bus.data_o !== 8'h61 || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL lsb_toggle got %h/%b want 61/1", bus.data_o, bus.valid_o); end
        consume();
    endtask

    task automatic test_overrun_clear();
        send_seq(8'hAC, 1'b0);
        send_seq(8'h61, 1'b0);
        total++; if (bus.data_o !== 8'hAC) begin bad++; $display("FAIL ovr_data got %h want ac", bus.data_o); end
        total++; if (bus.overrun_o !== 1'b1) begin bad++; $display("FAIL ovr_flag got %b want 1", bus.overrun_o); end
        repeat (2) tick();
        total++; if (bus.overrun_o !== 1'b1) begin bad++; $display("FAIL ovr_sticky got %b want 1", bus.overrun_o); end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        total++; if (bus.overrun_o !== 1'b0) begin bad++; $display("FAIL clr_overrun got %b want 0", bus.overrun_o); end
        total++; if (bus.valid_o !== 1'b1 || bus.data_o !== 8'hAC) begin
            bad++; $display("FAIL clr_keep got %h/%b want ac/1", bus.data_o, bus.valid_o); end
        // Word completing on the same edge the old one is drained replaces it without a gap.
        bus.right = 1'b0;
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h5A >> i));
`ifdef SIPO_PARITY_EN
        send_bit(1'b0);
`endif
        bus.ready_i = 1'b1;
`ifdef SIPO_PARITY_EN
        send_bit(1'b0);
`else
        send_bit(1'b0);
`endif
        bus.ready_i = 1'b0;
        total++; if (bus.data_o !== 8'h5A || bus.valid_o !== 1'b1 || bus.overrun_o !== 1'b0) begin
            bad++; $display("FAIL replace got %h/%b/%b want 5a/1/0", bus.data_o, bus.valid_o, bus.overrun_o); end
        consume();
    endtask

    task automatic test_clear_midword();
        bus.right = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        bus.clear    = 1'b1;
        bus.en       = 1'b1;
        bus.serial_i = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.en    = 1'b0;
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL clr_mid_valid got %b want 0", bus.valid_o); end
        send_seq(8'h5A, 1'b0);
        total++; if (bus.data_o !== 8'h5A || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL clr_mid_word got %h/%b want 5a/1", bus.data_o, bus.valid_o); end
        consume();
    endtask

    task automatic test_reset_midword();
        bus.right = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 7; i >= 3; i--) send_bit(1'(8'h3C >> i));
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got %b want 0", bus.valid_o); end
        for (int i = 2; i >= 0; i--) send_bit(1'(8'h3C >> i));
`ifdef SIPO_PARITY_EN
        send_bit(1'b0);
`endif
        total++; if (bus.data_o !== 8'h3C || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL rst_mid_word got %h/%b want 3c/1", bus.data_o, bus.valid_o); end
        consume();
    endtask

    task automatic test_parity();
        bus.right = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hAC >> i));
`ifdef SIPO_PARITY_EN
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL par_8th_valid got %b want 0", bus.valid_o); end
        send_bit(1'b1);
        total++; if (bus.valid_o !== 1'b1 || bus.parity_err_o !== 1'b1) begin
            bad++; $display("FAIL par_err got %b/%b want 1/1", bus.valid_o, bus.parity_err_o); end
        consume();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hAC >> i));
        send_bit(1'b0);
        total++; if (bus.valid_o !== 1'b1 || bus.parity_err_o !== 1'b0) begin
            bad++; $display("FAIL par_ok got %b/%b want 1/0", bus.valid_o, bus.parity_err_o); end
`else
        total++; if (bus.valid_o !== 1'b1 || bus.parity_err_o !== 1'b0) begin
            bad++; $display("FAIL nopar got %b/%b want 1/0", bus.valid_o, bus.parity_err_o); end
`endif
        consume();
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.right    = 1'b0;
        bus.serial_i = 1'b0;
        bus.clear    = 1'b0;
        bus.ready_i  = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overrun_clear();
        test_clear_midword();
        test_reset_midword();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
